// File: rtl/alu_if_pkg.sv
// -----------------------------------------------------------------------------
// alu_if_pkg
// Shared definitions for the UART <-> ALU frame controller:
//   - default widths of the UART byte, ALU opcode and ALU result
//   - result byte-split positions (low byte first, then the high part)
//   - 3-bit state encoding and the FSM state type
//   - ALU opcode constants
// -----------------------------------------------------------------------------
package alu_if_pkg;

    // Default widths
    localparam int NB_DATA_DEF     = 8;
    localparam int NB_OP_DEF       = 6;
    localparam int NB_DATA_OUT_DEF = 9;

    // Result byte split: the low byte goes out first, then the zero-extended
    // upper bits starting at RES_HI_LSB.
    localparam int RES_LO_LSB   = 0;
    localparam int RES_HI_LSB   = NB_DATA_DEF;
    localparam int RES_HI_WIDTH = NB_DATA_OUT_DEF - NB_DATA_DEF;

    // State encoding
    localparam logic [2:0] ST_GET_A   = 3'd0;
    localparam logic [2:0] ST_GET_B   = 3'd1;
    localparam logic [2:0] ST_GET_OP  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND_LO = 3'd4;
    localparam logic [2:0] ST_WAIT_LO = 3'd5;
    localparam logic [2:0] ST_SEND_HI = 3'd6;
    localparam logic [2:0] ST_WAIT_HI = 3'd7;

    typedef enum logic [2:0] {
        GET_A   = ST_GET_A,
        GET_B   = ST_GET_B,
        GET_OP  = ST_GET_OP,
        EXEC    = ST_EXEC,
        SEND_LO = ST_SEND_LO,
        WAIT_LO = ST_WAIT_LO,
        SEND_HI = ST_SEND_HI,
        WAIT_HI = ST_WAIT_HI
    } state_t;

    // ALU opcodes
    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_if_timeout.sv
// -----------------------------------------------------------------------------
// alu_if_timeout
// Inter-byte idle timer for the frame controller. Only compiled when the
// ALU_IF_TIMEOUT_EN macro is defined; the default build has no counter.
//
// A loadable down-counter: i_load restarts the interval, i_enable lets it
// count down, and o_expired is high while enabled with the count at zero,
// i.e. once TIMEOUT_CYCLES-1 enabled cycles have elapsed since the load.
//
// Ports:
//   i_clock     in   clock, rising edge
//   i_reset_n   in   asynchronous active-low reset
//   i_load      in   restart the interval (an accepted byte)
//   i_enable    in   count this cycle (waiting for the next byte)
//   o_expired   out  interval elapsed
// -----------------------------------------------------------------------------
`ifdef ALU_IF_TIMEOUT_EN
module alu_if_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= LOAD_VAL;
        end else if (i_enable && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (count_q == '0);

endmodule
`endif

// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
// Frame controller between the UART byte receiver/transmitter and a
// combinational ALU. Collects operand A, operand B and the opcode from three
// received bytes, lets the ALU settle for one cycle, then sends the result
// back as two bytes (low byte first) using the transmitter start/done
// handshake. Bytes received while a frame is executing or being sent are
// dropped and flagged on o_overrun.
//
// Optional feature: define ALU_IF_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles in GET_B/GET_OP (o_timeout pulses). Without it
// the block waits indefinitely and o_timeout stays 0.
//
// Ports:
//   i_clock        in   clock, rising edge
//   i_reset_n      in   asynchronous active-low reset
//   i_rx_data      in   received byte, valid with i_rx_done
//   i_rx_done      in   one-cycle pulse, byte available
//   o_alu_data_a   out  operand A (registered)
//   o_alu_data_b   out  operand B (registered)
//   o_alu_code     out  opcode (registered)
//   i_alu_result   in   combinational ALU result
//   o_tx_data      out  byte to transmit, stable from o_tx_start to i_tx_done
//   o_tx_start     out  one-cycle pulse, start transmission
//   i_tx_done      in   one-cycle pulse, transmitter finished a byte
//   o_busy         out  high in every state except GET_A
//   o_overrun      out  one-cycle pulse, a received byte was dropped
//   o_timeout      out  one-cycle pulse, partial frame aborted
// -----------------------------------------------------------------------------
module alu_uart_interface
    import alu_if_pkg::*;
#(
    parameter int          NB_DATA        = NB_DATA_DEF,
    parameter int          NB_OP          = NB_OP_DEF,
    parameter int          NB_DATA_OUT    = NB_DATA_OUT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    output logic [NB_DATA-1:0]     o_alu_data_a,
    output logic [NB_DATA-1:0]     o_alu_data_b,
    output logic [NB_OP-1:0]       o_alu_code,
    input  logic [NB_DATA_OUT-1:0] i_alu_result,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic                   o_timeout
);

    localparam int NB_HI = NB_DATA_OUT - NB_DATA;

    // Elaboration-time parameter sanity checks
    if (!((NB_DATA < NB_DATA_OUT) && (NB_DATA_OUT <= 2 * NB_DATA))) begin : g_bad_widths
        $error("alu_uart_interface: NB_DATA_OUT must satisfy NB_DATA < NB_DATA_OUT <= 2*NB_DATA");
    end
    if (NB_OP > NB_DATA) begin : g_bad_op_width
        $error("alu_uart_interface: NB_OP must not exceed NB_DATA");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("alu_uart_interface: TIMEOUT_CYCLES must be at least 2");
    end

    state_t           state;
    // The low result byte is loaded straight into o_tx_data in EXEC, so only
    // the upper part of the result has to be held until the second byte.
    logic [NB_HI-1:0] result_hi_q;
    logic             timeout_hit;

`ifdef ALU_IF_TIMEOUT_EN
    logic to_load;
    logic to_enable;

    // Restart on each accepted byte that leads into GET_B/GET_OP; count only
    // on idle cycles while a frame is partially received.
    assign to_load   = i_rx_done && ((state == GET_A) || (state == GET_B));
    assign to_enable = !i_rx_done && ((state == GET_B) || (state == GET_OP));

    alu_if_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (to_load),
        .i_enable  (to_enable),
        .o_expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all updates
    // within the edge see the pre-edge state; pulse outputs get a default of
    // 0 at the top of the block and a branch raises them for one cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= GET_A;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            o_alu_code   <= '0;
            result_hi_q  <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
            o_timeout  <= 1'b0;

            case (state)
                GET_A: begin
                    if (i_rx_done) begin
                        o_alu_data_a <= i_rx_data;
                        o_busy       <= 1'b1;
                        state        <= GET_B;
                    end
                end

                GET_B: begin
                    if (i_rx_done) begin
                        o_alu_data_b <= i_rx_data;
                        state        <= GET_OP;
                    end else if (timeout_hit) begin
                        o_busy    <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end

                GET_OP: begin
                    if (i_rx_done) begin
                        o_alu_code <= i_rx_data[NB_OP-1:0];
                        state      <= EXEC;
                    end else if (timeout_hit) begin
                        o_busy    <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end

                // ALU inputs have been stable for this whole cycle.
                EXEC: begin
                    result_hi_q <= i_alu_result[NB_DATA_OUT-1:NB_DATA];
                    o_tx_data   <= i_alu_result[NB_DATA-1:0];
                    o_tx_start  <= 1'b1;
                    state       <= SEND_LO;
                end

                SEND_LO: state <= WAIT_LO;

                WAIT_LO: begin
                    if (i_tx_done) begin
                        o_tx_data  <= NB_DATA'(result_hi_q);
                        o_tx_start <= 1'b1;
                        state      <= SEND_HI;
                    end
                end

                SEND_HI: state <= WAIT_HI;

                WAIT_HI: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= GET_A;
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= GET_A;
                end
            endcase

            // Any byte arriving outside the GET_* states is dropped.
            if (i_rx_done && !((state == GET_A) || (state == GET_B) || (state == GET_OP))) begin
                o_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_interface
// Directed and randomized frames for alu_uart_interface. The bench plays the
// UART receiver, the ALU (behavioural model) and the UART transmitter.
// Expected values come from the ALU model applied to the stimulus bytes and
// from the frame timing rules. Define ALU_IF_TIMEOUT_EN to add the idle
// timeout scenario.
// -----------------------------------------------------------------------------
module tb_alu_uart_interface;
    import alu_if_pkg::*;

    localparam int NB_DATA        = 8;
    localparam int NB_OP          = 6;
    localparam int NB_DATA_OUT    = 9;
    localparam int TIMEOUT_CYCLES = 16;

    logic                   i_clock = 1'b0;
    logic                   i_reset_n = 1'b0;
    logic [NB_DATA-1:0]     i_rx_data = '0;
    logic                   i_rx_done = 1'b0;
    logic [NB_DATA-1:0]     o_alu_data_a;
    logic [NB_DATA-1:0]     o_alu_data_b;
    logic [NB_OP-1:0]       o_alu_code;
    logic [NB_DATA_OUT-1:0] i_alu_result;
    logic [NB_DATA-1:0]     o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done = 1'b0;
    logic                   o_busy;
    logic                   o_overrun;
    logic                   o_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 i_clock = ~i_clock;

    // Behavioural ALU: unknown opcodes return 0.
    function automatic logic [NB_DATA_OUT-1:0] alu_model(input logic [7:0] a,
                                                          input logic [7:0] b,
                                                          input logic [5:0] code);
        logic signed [8:0] sa;
        sa = {a[7], a};
        case (code)
            OP_ADD:  return 9'(a) + 9'(b);
            OP_SUB:  return 9'(a) - 9'(b);
            OP_AND:  return 9'(a & b);
            OP_OR:   return 9'(a | b);
            OP_XOR:  return 9'(a ^ b);
            OP_NOR:  return 9'(~(a | b));
            OP_SRA:  return 9'(sa >>> b);
            OP_SRL:  return 9'(a >> b);
            default: return '0;
        endcase
    endfunction

    assign i_alu_result = alu_model(o_alu_data_a, o_alu_data_b, o_alu_code);

    alu_uart_interface #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .NB_DATA_OUT    (NB_DATA_OUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .o_alu_data_a (o_alu_data_a),
        .o_alu_data_b (o_alu_data_b),
        .o_alu_code   (o_alu_code),
        .i_alu_result (i_alu_result),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},       32'(o_alu_data_a), 32'h0);
        check({tag, "_b"},       32'(o_alu_data_b), 32'h0);
        check({tag, "_code"},    32'(o_alu_code),   32'h0);
        check({tag, "_txdata"},  32'(o_tx_data),    32'h0);
        check({tag, "_txstart"}, 32'(o_tx_start),   32'h0);
        check({tag, "_busy"},    32'(o_busy),       32'h0);
        check({tag, "_overrun"}, 32'(o_overrun),    32'h0);
        check({tag, "_timeout"}, 32'(o_timeout),    32'h0);
    endtask

    // One complete frame with the bench acting as receiver and transmitter.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input int gap_max, input int d_lo,
                             input int d_hi, input bit ovr_lo, input bit ovr_hi);
        logic [NB_DATA_OUT-1:0] exp_res;
        logic [7:0]             exp_lo;
        logic [7:0]             exp_hi;
        exp_res = alu_model(a, b, op[5:0]);
        exp_lo  = exp_res[7:0];
        exp_hi  = 8'(exp_res >> RES_HI_LSB);

        repeat ($urandom_range(gap_max, 0)) tick();
        send_byte(a);
        @(negedge i_clock);
        check({tag, "_busy_after_a"}, 32'(o_busy), 32'h1);
        repeat ($urandom_range(gap_max, 0)) tick();
        send_byte(b);
        repeat ($urandom_range(gap_max, 0)) tick();
        send_byte(op);

        // EXEC cycle: operands presented to the ALU
        @(negedge i_clock);
        check({tag, "_alu_a"},    32'(o_alu_data_a), 32'(a));
        check({tag, "_alu_b"},    32'(o_alu_data_b), 32'(b));
        check({tag, "_alu_code"}, 32'(o_alu_code),   32'(op[5:0]));
        check({tag, "_exec_nostart"}, 32'(o_tx_start), 32'h0);

        // Low byte start, two cycles after the opcode pulse
        tick();
        @(negedge i_clock);
        check({tag, "_start_lo"}, 32'(o_tx_start), 32'h1);
        check({tag, "_data_lo"},  32'(o_tx_data),  32'(exp_lo));
        tick();
        @(negedge i_clock);
        check({tag, "_start_lo_pulse"}, 32'(o_tx_start), 32'h0);

        if (ovr_lo) begin
            i_rx_data = 8'($urandom);
            i_rx_done = 1'b1;
            tick();
            i_rx_done = 1'b0;
            @(negedge i_clock);
            check({tag, "_overrun_lo"}, 32'(o_overrun), 32'h1);
            tick();
            @(negedge i_clock);
            check({tag, "_overrun_lo_pulse"}, 32'(o_overrun), 32'h0);
        end

        repeat (d_lo) tick();
        check({tag, "_hold_lo"}, 32'(o_tx_data), 32'(exp_lo));
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;

        // High byte start, one cycle after the first done
        @(negedge i_clock);
        check({tag, "_start_hi"}, 32'(o_tx_start), 32'h1);
        check({tag, "_data_hi"},  32'(o_tx_data),  32'(exp_hi));
        tick();
        @(negedge i_clock);
        check({tag, "_start_hi_pulse"}, 32'(o_tx_start), 32'h0);
        check({tag, "_busy_wait_hi"},   32'(o_busy),     32'h1);

        repeat (d_hi) tick();
        i_tx_done = 1'b1;
        if (ovr_hi) begin
            i_rx_data = 8'($urandom);
            i_rx_done = 1'b1;
        end
        tick();
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        @(negedge i_clock);
        check({tag, "_idle_busy"},    32'(o_busy),     32'h0);
        check({tag, "_idle_overrun"}, 32'(o_overrun),  32'(ovr_hi));
        check({tag, "_idle_start"},   32'(o_tx_start), 32'h0);
    endtask

    // Watchdog: the sequence below is fixed-length, so this only trips if
    // simulation time runs away.
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

        // Reset state
        repeat (3) tick();
        @(negedge i_clock);
        check_all_zero("reset");
        tick();
        i_reset_n = 1'b1;
        tick();

        // Basic ADD, then carry into the high byte
        run_frame("add_small", 8'h05, 8'h03, 8'h20, 0, 2, 1, 1'b0, 1'b0);
        run_frame("add_carry", 8'hFF, 8'h01, 8'h20, 0, 0, 3, 1'b0, 1'b0);

        // Extra byte while waiting for the low-byte done, then a clean frame
        run_frame("ovr_lo", 8'h12, 8'h34, 8'h20, 0, 1, 0, 1'b1, 1'b0);
        run_frame("after_ovr", 8'h40, 8'h11, 8'h22, 0, 0, 0, 1'b0, 1'b0);

        // Byte arriving together with the final done is still dropped
        run_frame("ovr_hi", 8'h0F, 8'hF0, 8'h25, 1, 0, 2, 1'b0, 1'b1);

        // Unknown opcode (upper bits of the opcode byte ignored)
        run_frame("unknown_op", 8'h77, 8'h22, 8'hFF, 0, 0, 0, 1'b0, 1'b0);

        // Done pulse while idle is ignored
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        @(negedge i_clock);
        check("idle_done_start", 32'(o_tx_start), 32'h0);
        check("idle_done_busy",  32'(o_busy),     32'h0);

        // Reset in WAIT_HI
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h20);
        tick();
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        @(negedge i_clock);
        check("pre_reset_busy", 32'(o_busy), 32'h1);
        i_reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        i_reset_n = 1'b1;
        repeat (3) tick();
        @(negedge i_clock);
        check("post_reset_start", 32'(o_tx_start), 32'h0);
        check("post_reset_busy",  32'(o_busy),     32'h0);
        run_frame("sub_after_reset", 8'h0A, 8'h02, 8'h22, 0, 1, 1, 1'b0, 1'b0);

`ifdef ALU_IF_TIMEOUT_EN
        begin
            int pulses;
            int at;
            pulses = 0;
            at     = 0;
            send_byte(8'h11);
            for (int k = 1; k <= 20; k++) begin
                @(negedge i_clock);
                if (o_timeout === 1'b1) begin
                    pulses++;
                    at = k;
                end
                tick();
            end
            check("timeout_pulses", 32'(pulses), 32'd1);
            check("timeout_window", 32'((at >= TIMEOUT_CYCLES) && (at <= TIMEOUT_CYCLES + 1)), 32'h1);
            @(negedge i_clock);
            check("timeout_busy", 32'(o_busy), 32'h0);
            run_frame("after_timeout", 8'h21, 8'h13, 8'h26, 0, 0, 0, 1'b0, 1'b0);
        end
`endif

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [7:0] op;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(3, 0) == 0) op = 8'($urandom);
            else op = {($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00, ops[$urandom_range(7, 0)][5:0]};
            run_frame($sformatf("rand%0d", i), a, b, op, 3,
                      $urandom_range(4, 0), $urandom_range(4, 0),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
